wb_port_arbiter: RTL and testbench

//  Shares the NR_PORTS writeback ports between NR_REQ functional-unit result

---
 rtl/wb_port_arbiter_if.sv | 26 ++
 rtl/wb_port_arbiter.sv | 92 +++++++++
 tb/tb_wb_port_arbiter.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/wb_port_arbiter_if.sv
// Requester-side and writeback-side signals of the writeback port arbiter.
// master = functional-unit side, slave = arbiter.
interface wb_port_arbiter_if #(
  parameter int NR_REQ   = 4,
  parameter int NR_PORTS = 2,
  parameter int W        = 128
);
  localparam int SRC_W = $clog2(NR_REQ);

  logic [NR_REQ-1:0]                req_valid_i;
  logic [NR_REQ-1:0][W-1:0]         req_data_i;
  logic [NR_REQ-1:0]                req_ready_o;
  logic [NR_PORTS-1:0]              wb_valid_o;
  logic [NR_PORTS-1:0][W-1:0]       wb_data_o;
  logic [NR_PORTS-1:0][SRC_W-1:0]   wb_src_o;

  modport master (
    output req_valid_i, req_data_i,
    input  req_ready_o, wb_valid_o, wb_data_o, wb_src_o
  );

  modport slave (
    input  req_valid_i, req_data_i,
    output req_ready_o, wb_valid_o, wb_data_o, wb_src_o
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter granting up to NR_PORTS of NR_REQ FU results per cycle onto
// registered writeback ports, with a saturating port-contention cycle counter.
module wb_port_arbiter #(
  parameter int NR_REQ   = 4,
  parameter int NR_PORTS = 2,
  parameter int W        = 128,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                flush_i,
  wb_port_arbiter_if.slave    bus,
  output logic [CNT_W-1:0]    stall_cnt_o
);
  localparam int SRC_W = $clog2(NR_REQ);

  logic [SRC_W-1:0]                 ptr_q, ptr_d;
  logic [2*NR_REQ-1:0]              valid_dup;
  logic [NR_REQ-1:0]                valid_rot;
  logic [NR_REQ-1:0]                grant_rot;
  logic [2*NR_REQ-1:0]              grant_dup;
  logic [NR_REQ-1:0]                grant;
  logic [NR_PORTS-1:0]              port_hit;
  logic [NR_PORTS-1:0][SRC_W-1:0]   port_src;
  logic                             contention;
  int                               n_grant;
  int                               scan_idx;

  logic [NR_PORTS-1:0]              wb_valid_q;
  logic [NR_PORTS-1:0][W-1:0]       wb_data_q;
  logic [NR_PORTS-1:0][SRC_W-1:0]   wb_src_q;
  logic [CNT_W-1:0]                 stall_q;

  // Rotate valids so bit k is requester (ptr+k) mod NR_REQ; scan with constant indices.
  always_comb begin
    valid_dup = {bus.req_valid_i, bus.req_valid_i} >> ptr_q;
    valid_rot = valid_dup[NR_REQ-1:0];
    grant_rot = '0;
    port_hit  = '0;
    port_src  = '0;
    ptr_d     = ptr_q;
    n_grant   = 0;
    scan_idx  = 0;
    for (int k = 0; k < NR_REQ; k++) begin
      scan_idx = int'(ptr_q) + k;
      if (scan_idx >= NR_REQ) scan_idx = scan_idx - NR_REQ;
      if (!flush_i && valid_rot[k] && n_grant < NR_PORTS) begin
        grant_rot[k] = 1'b1;
        for (int p = 0; p < NR_PORTS; p++) begin
          if (p == n_grant) begin
            port_hit[p] = 1'b1;
            port_src[p] = SRC_W'(scan_idx);
          end
        end
        n_grant = n_grant + 1;
        ptr_d   = (scan_idx + 1 >= NR_REQ) ? '0 : SRC_W'(scan_idx + 1);
      end
    end
  end

  always_comb begin
    grant_dup  = {{NR_REQ{1'b0}}, grant_rot} << ptr_q;
    grant      = grant_dup[NR_REQ-1:0] | grant_dup[2*NR_REQ-1:NR_REQ];
    contention = !flush_i && ((bus.req_valid_i & ~grant) != '0);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wb_valid_q <= '0;
      wb_data_q  <= '0;
      wb_src_q   <= '0;
      ptr_q      <= '0;
      stall_q    <= '0;
    end else begin
      wb_valid_q <= port_hit;
      for (int p = 0; p < NR_PORTS; p++) begin
        if (port_hit[p]) begin
          wb_data_q[p] <= bus.req_data_i[port_src[p]];
          wb_src_q[p]  <= port_src[p];
        end
      end
      ptr_q <= ptr_d;
      if (contention && !(&stall_q)) stall_q <= stall_q + 1'b1;
    end
  end

  assign bus.req_ready_o = grant;
  assign bus.wb_valid_o  = wb_valid_q;
  assign bus.wb_data_o   = wb_data_q;
  assign bus.wb_src_o    = wb_src_q;
  assign stall_cnt_o     = stall_q;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: a queue-based round-robin reference model
// predicts ready, writeback ports and contention count; a negedge monitor compares.
module tb_wb_port_arbiter;
  localparam int N  = 4;
  localparam int P  = 2;
  localparam int W  = 32;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic flush = 1'b0;
  logic [CW-1:0] stall_cnt;

  wb_port_arbiter_if #(.NR_REQ(N), .NR_PORTS(P), .W(W)) bus ();

  wb_port_arbiter #(.NR_REQ(N), .NR_PORTS(P), .W(W), .CNT_W(CW)) dut (
    .clk(clk),
    .rstn(rstn),
    .flush_i(flush),
    .bus(bus),
    .stall_cnt_o(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                       cyc;
    logic [N-1:0]             ready;
    logic [P-1:0]             wbv;
    logic [P-1:0][1:0]        src;
    logic [P-1:0][W-1:0]      data;
    logic [CW-1:0]            stall;
  } exp_t;

  exp_t rdy_q[$];
  exp_t wb_q[$];
  exp_t mon_e;
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  int         m_ptr = 0;
  int         m_stall = 0;
  bit         pend[N];
  logic [W-1:0] pdata[N];
  int         m_src[P];
  logic [W-1:0] m_data[P];
  int         waitc[N];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  // One clock of stimulus; the model decides which pending requests win this cycle.
  task automatic drive_cycle(input bit rst, input bit fl, input logic [N-1:0] new_mask,
                             input logic [W-1:0] dfix);
    exp_t er;
    exp_t ew;
    int granted[$];
    bit left;
    @(posedge clk);
    #1;
    cyc++;
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && new_mask[i]) begin
          pend[i]  = 1'b1;
          pdata[i] = (dfix != '0) ? dfix : W'($urandom);
        end
      end
    end
    rstn  = !rst;
    flush = fl;
    for (int i = 0; i < N; i++) begin
      bus.req_valid_i[i] = pend[i] && !rst;
      bus.req_data_i[i]  = pdata[i];
    end
    er.cyc   = cyc;
    er.ready = '0;
    er.wbv   = '0;
    er.src   = '0;
    er.data  = '0;
    er.stall = '0;
    ew       = er;
    ew.cyc   = cyc + 1;
    if (rst) begin
      m_ptr   = 0;
      m_stall = 0;
      for (int p = 0; p < P; p++) begin
        m_src[p]  = 0;
        m_data[p] = '0;
      end
      for (int i = 0; i < N; i++) pend[i] = 1'b0;
    end else if (!fl) begin
      for (int k = 0; k < N; k++) begin
        if (pend[(m_ptr + k) % N] && granted.size() < P) granted.push_back((m_ptr + k) % N);
      end
      foreach (granted[g]) begin
        er.ready[granted[g]] = 1'b1;
        ew.wbv[g]            = 1'b1;
        m_src[g]             = granted[g];
        m_data[g]            = pdata[granted[g]];
        pend[granted[g]]     = 1'b0;
      end
      left = 1'b0;
      for (int i = 0; i < N; i++) if (pend[i]) left = 1'b1;
      if (left && m_stall < (1 << CW) - 1) m_stall++;
      if (granted.size() > 0) m_ptr = (granted[granted.size() - 1] + 1) % N;
    end
    ew.stall = CW'(m_stall);
    for (int p = 0; p < P; p++) begin
      ew.src[p]  = 2'(m_src[p]);
      ew.data[p] = m_data[p];
    end
    rdy_q.push_back(er);
    wb_q.push_back(ew);
  endtask

  always @(negedge clk) begin
    while (rdy_q.size() > 0 && rdy_q[0].cyc <= cyc) begin
      mon_e = rdy_q.pop_front();
      chk("ready", 64'(bus.req_ready_o), 64'(mon_e.ready));
    end
    while (wb_q.size() > 0 && wb_q[0].cyc <= cyc) begin
      mon_e = wb_q.pop_front();
      chk("wb_valid", 64'(bus.wb_valid_o), 64'(mon_e.wbv));
      chk("stall_cnt", 64'(stall_cnt), 64'(mon_e.stall));
      for (int p = 0; p < P; p++) begin
        chk("wb_src", 64'(bus.wb_src_o[p]), 64'(mon_e.src[p]));
        chk("wb_data", 64'(bus.wb_data_o[p]), 64'(mon_e.data[p]));
      end
    end
    // Every valid requester must be granted no later than the cycle after it waits once.
    for (int i = 0; i < N; i++) begin
      if (!rstn) begin
        waitc[i] = 0;
      end else if (bus.req_valid_i[i]) begin
        if (bus.req_ready_o[i]) begin
          chk("grant_age", 64'(waitc[i] < 2), 64'd1);
          waitc[i] = 0;
        end else if (!flush) begin
          waitc[i]++;
        end
      end
    end
  end

  initial begin
    bus.req_valid_i = '0;
    bus.req_data_i  = '0;
    for (int i = 0; i < N; i++) begin
      pend[i]  = 1'b0;
      pdata[i] = '0;
      waitc[i] = 0;
    end
    for (int p = 0; p < P; p++) begin
      m_src[p]  = 0;
      m_data[p] = '0;
    end

    drive_cycle(1, 0, 4'h0, '0);
    drive_cycle(1, 0, 4'h0, '0);
    // all four valid from ptr=0, two cycles
    drive_cycle(0, 0, 4'hF, '0);
    drive_cycle(0, 0, 4'h0, '0);
    drive_cycle(0, 0, 4'h0, '0);
    // lone requester 3 with a fixed payload
    drive_cycle(0, 0, 4'b1000, 32'hA5);
    drive_cycle(0, 0, 4'h0, '0);
    // move ptr to 2, then flush with everyone valid, then release
    drive_cycle(0, 0, 4'b0011, '0);
    drive_cycle(0, 1, 4'hF, '0);
    drive_cycle(0, 0, 4'h0, '0);
    drive_cycle(0, 0, 4'h0, '0);
    // mid-stream reset while both ports are busy and ptr=2
    drive_cycle(0, 0, 4'hF, '0);
    drive_cycle(1, 0, 4'h0, '0);
    drive_cycle(0, 0, 4'hF, '0);
    drive_cycle(0, 0, 4'h0, '0);
    // saturation of the 4-bit counter
    drive_cycle(1, 0, 4'h0, '0);
    for (int c = 0; c < 20; c++) drive_cycle(0, 0, 4'hF, '0);
    // randomized stress with occasional flush and reset
    for (int c = 0; c < 1500; c++) begin
      drive_cycle($urandom_range(0, 199) == 0, $urandom_range(0, 15) == 0,
                  N'($urandom_range(0, 15)), '0);
    end
    drive_cycle(0, 0, 4'h0, '0);
    drive_cycle(0, 0, 4'h0, '0);

    @(posedge clk);
    #1;
    cyc++;
    @(negedge clk);
    #1;
    chk("drain", 64'(rdy_q.size() + wb_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
